// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter that shares one drink dispenser and one coin-return hopper between two panels.
// Define VEND_STATS_EN to add saturating per-drink successful-vend counters.
module vend_dispense_arbiter #(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic        drink_type0_i,
    input  logic        drink_type1_i,
    input  logic [1:0]  change0_i,
    input  logic [1:0]  change1_i,
    input  logic        drop_ok_i,
    input  logic        coin_ack_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic        motor_coke_o,
    output logic        motor_sprite_o,
    output logic        coin_out_o,
`ifdef VEND_STATS_EN
    output logic [15:0] cnt_coke_o,
    output logic [15:0] cnt_sprite_o,
`endif
    output logic        busy_o
);

    typedef enum logic [2:0] {IDLE, GRANT, MOTOR, WAIT_DROP, PAYOUT, GAP, DONE} state_e;

    localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DROP_LAST  = CNT_W'(DROP_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              drink_q, drink_d;
    logic [1:0]        changeLeft_q, changeLeft_d;
    logic              errLatched_q, errLatched_d;
    logic              lastServed_q, lastServed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        gnt_d, done_d;
    logic              err_d, motorCoke_d, motorSprite_d, coinOut_d, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sel_q          <= 1'b0;
            drink_q        <= 1'b0;
            changeLeft_q   <= 2'd0;
            errLatched_q   <= 1'b0;
            lastServed_q   <= 1'b1;
            cnt_q          <= '0;
            gnt_o          <= 2'b00;
            done_o         <= 2'b00;
            err_o          <= 1'b0;
            motor_coke_o   <= 1'b0;
            motor_sprite_o <= 1'b0;
            coin_out_o     <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            drink_q        <= drink_d;
            changeLeft_q   <= changeLeft_d;
            errLatched_q   <= errLatched_d;
            lastServed_q   <= lastServed_d;
            cnt_q          <= cnt_d;
            gnt_o          <= gnt_d;
            done_o         <= done_d;
            err_o          <= err_d;
            motor_coke_o   <= motorCoke_d;
            motor_sprite_o <= motorSprite_d;
            coin_out_o     <= coinOut_d;
            busy_o         <= busy_d;
        end
    end

    // On a tie the panel that was not served last wins.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        drink_d      = drink_q;
        changeLeft_d = changeLeft_q;
        errLatched_d = errLatched_q;
        lastServed_d = lastServed_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    sel_d        = (req_i == 2'b11) ? ~lastServed_q : req_i[1];
                    drink_d      = sel_d ? drink_type1_i : drink_type0_i;
                    changeLeft_d = sel_d ? change1_i : change0_i;
                    errLatched_d = 1'b0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = '0;
                state_d = MOTOR;
            end
            MOTOR: begin
                if (cnt_q == MOTOR_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_DROP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DROP: begin
                if (drop_ok_i || (cnt_q == DROP_LAST)) begin
                    if (!drop_ok_i) begin
                        errLatched_d = 1'b1;
                    end
                    state_d = (changeLeft_q != 2'd0) ? PAYOUT : DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PAYOUT: begin
                if (coin_ack_i) begin
                    changeLeft_d = changeLeft_q - 2'd1;
                    state_d      = (changeLeft_q > 2'd1) ? GAP : DONE;
                end
            end
            GAP: state_d = PAYOUT;
            DONE: begin
                lastServed_d = sel_q;
                errLatched_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        gnt_d         = 2'b00;
        done_d        = 2'b00;
        err_d         = 1'b0;
        motorCoke_d   = 1'b0;
        motorSprite_d = 1'b0;
        coinOut_d     = 1'b0;
        busy_d        = (state_d != IDLE);
        case (state_d)
            GRANT:  gnt_d[sel_d] = 1'b1;
            MOTOR: begin
                motorCoke_d   = ~drink_d;
                motorSprite_d = drink_d;
            end
            PAYOUT: coinOut_d = 1'b1;
            DONE: begin
                done_d[sel_d] = 1'b1;
                err_d         = errLatched_d;
            end
            default: ;
        endcase
    end

`ifdef VEND_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_coke_o   <= 16'd0;
            cnt_sprite_o <= 16'd0;
        end else if ((state_q == DONE) && !errLatched_q) begin
            if (!drink_q && (cnt_coke_o != 16'hFFFF)) begin
                cnt_coke_o <= cnt_coke_o + 16'd1;
            end
            if (drink_q && (cnt_sprite_o != 16'hFFFF)) begin
                cnt_sprite_o <= cnt_sprite_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed self-checking bench for vend_dispense_arbiter (default parameters).
// Build with VEND_STATS_EN defined to also exercise the vend counters.
module tb_vend_dispense_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic        drinkType0, drinkType1;
    logic [1:0]  change0, change1;
    logic        dropOk, coinAck;
    logic [1:0]  gnt, done;
    logic        err, motorCoke, motorSprite, coinOut, busy;
`ifdef VEND_STATS_EN
    logic [15:0] cntCoke, cntSprite;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vend_dispense_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .drink_type0_i  (drinkType0),
        .drink_type1_i  (drinkType1),
        .change0_i      (change0),
        .change1_i      (change1),
        .drop_ok_i      (dropOk),
        .coin_ack_i     (coinAck),
        .gnt_o          (gnt),
        .done_o         (done),
        .err_o          (err),
        .motor_coke_o   (motorCoke),
        .motor_sprite_o (motorSprite),
        .coin_out_o     (coinOut),
`ifdef VEND_STATS_EN
        .cnt_coke_o     (cntCoke),
        .cnt_sprite_o   (cntSprite),
`endif
        .busy_o         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = 2'b00;
        dropOk = 1'b0;
        coinAck = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 2'b00; drinkType0 = 1'b0; drinkType1 = 1'b0;
        change0 = 2'd0; change1 = 2'd0; dropOk = 1'b0; coinAck = 1'b0;
        #3;
        checks++;
        if ({gnt, done, err, motorCoke, motorSprite, coinOut, busy} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b want %b",
                     {gnt, done, err, motorCoke, motorSprite, coinOut, busy}, 9'b0);
        end
        step();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({gnt, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b want %b", {gnt, busy}, 3'b000);
        end
`ifdef VEND_STATS_EN
        checks++;
        if ({cntCoke, cntSprite} !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %h want %h", {cntCoke, cntSprite}, 32'd0);
        end
`endif
    endtask

    task automatic test_single();
        int hi;
        req = 2'b01; drinkType0 = 1'b0; change0 = 2'd1; dropOk = 1'b0; coinAck = 1'b0;
        step();
        checks++;
        if ({gnt, busy, motorCoke, motorSprite} !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b want %b", {gnt, busy, motorCoke, motorSprite}, 5'b01100);
        end
        req = 2'b00;
        step();
        checks++;
        if ({gnt, motorCoke, motorSprite} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_motor_on: got %b want %b", {gnt, motorCoke, motorSprite}, 4'b0010);
        end
        hi = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (motorCoke === 1'b1) hi++;
        end
        checks++;
        if (hi != 8 || motorCoke !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_motor_len: got %0d cycles (now %b) want 8 cycles (now 0)", hi, motorCoke);
        end
        step();
        step();
        checks++;
        if (coinOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_no_early_coin: got %b want 0", coinOut);
        end
        dropOk = 1'b1;
        step();
        dropOk = 1'b0;
        checks++;
        if ({coinOut, done} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL single_coin_on: got %b want %b", {coinOut, done}, 3'b100);
        end
        step();
        checks++;
        if (coinOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_coin_held: got %b want 1", coinOut);
        end
        coinAck = 1'b1;
        step();
        coinAck = 1'b0;
        checks++;
        if ({coinOut, done, err} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_done: got %b want %b", {coinOut, done, err}, 4'b0010);
        end
        step();
        checks++;
        if ({done, err, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_idle: got %b want %b", {done, err, busy}, 4'b0000);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        int n;
        do_reset();
        drinkType0 = 1'b0; drinkType1 = 1'b1; change0 = 2'd0; change1 = 2'd0;
        dropOk = 1'b1; req = 2'b11;
        for (int s = 0; s < 3; s++) begin
            want = (s == 1) ? 2'b10 : 2'b01;
            n = 0;
            while (gnt === 2'b00 && n < 20) begin
                step();
                n++;
            end
            checks++;
            if (gnt !== want) begin
                errors++;
                $display("[TB] FAIL rr_gnt%0d: got %b want %b", s, gnt, want);
            end
            step();
            checks++;
            if ({motorCoke, motorSprite} !== {~want[1], want[1]}) begin
                errors++;
                $display("[TB] FAIL rr_motor%0d: got %b want %b", s, {motorCoke, motorSprite}, {~want[1], want[1]});
            end
            n = 1;
            while (done === 2'b00 && n < 40) begin
                step();
                n++;
            end
            checks++;
            if (done !== want || err !== 1'b0 || n != 10) begin
                errors++;
                $display("[TB] FAIL rr_done%0d: got done=%b err=%b after %0d cycles want done=%b err=0 after 10",
                         s, done, err, n, want);
            end
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_timeout();
        int hi;
        int n;
        bit sawDone;
        req = 2'b10; drinkType1 = 1'b1; change1 = 2'd2; dropOk = 1'b0; coinAck = 1'b0;
        step();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("[TB] FAIL to_gnt: got %b want %b", gnt, 2'b10);
        end
        req = 2'b00;
        step();
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if ({motorCoke, motorSprite} === 2'b01) hi++;
            step();
        end
        checks++;
        if (hi != 8 || {motorCoke, motorSprite} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL to_motor: got %0d sprite cycles (now %b) want 8 (now 00)", hi, {motorCoke, motorSprite});
        end
        n = 0;
        sawDone = 1'b0;
        while (coinOut !== 1'b1 && n < 200) begin
            step();
            n++;
            if (done !== 2'b00) sawDone = 1'b1;
        end
        checks++;
        if (n != 64 || sawDone) begin
            errors++;
            $display("[TB] FAIL to_wait_len: got %0d cycles (early done %0d) want 64 (early done 0)", n, sawDone);
        end
        coinAck = 1'b1;
        step();
        coinAck = 1'b0;
        checks++;
        if ({coinOut, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL to_gap: got %b want %b", {coinOut, done}, 3'b000);
        end
        step();
        checks++;
        if (coinOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_coin2: got %b want 1", coinOut);
        end
        coinAck = 1'b1;
        step();
        coinAck = 1'b0;
        checks++;
        if ({coinOut, done, err} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL to_done_err: got %b want %b", {coinOut, done, err}, 4'b0101);
        end
        step();
        checks++;
        if ({done, err, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL to_idle: got %b want %b", {done, err, busy}, 4'b0000);
        end
    endtask

    task automatic test_change3();
        int hi;
        int n;
        req = 2'b01; drinkType0 = 1'b0; change0 = 2'd3; dropOk = 1'b1; coinAck = 1'b0;
        step();
        req = 2'b00;
        n = 0;
        while (coinOut !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            hi = (coinOut === 1'b1) ? 1 : 0;
            for (int j = 0; j < 4; j++) begin
                step();
                if (coinOut === 1'b1) hi++;
            end
            coinAck = 1'b1;
            step();
            coinAck = 1'b0;
            checks++;
            if (hi != 5 || coinOut !== 1'b0) begin
                errors++;
                $display("[TB] FAIL c3_hold%0d: got %0d high cycles (now %b) want 5 (now 0)", k, hi, coinOut);
            end
            if (k < 2) begin
                checks++;
                if (done !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL c3_early_done%0d: got %b want 00", k, done);
                end
                step();
                checks++;
                if (coinOut !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL c3_gap%0d: got %b want 1", k, coinOut);
                end
            end else begin
                checks++;
                if ({done, err} !== 3'b010) begin
                    errors++;
                    $display("[TB] FAIL c3_done: got %b want %b", {done, err}, 3'b010);
                end
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        bit sawCoin;
        req = 2'b01; drinkType0 = 1'b0; change0 = 2'd3; dropOk = 1'b1; coinAck = 1'b0;
        step();
        req = 2'b00;
        n = 0;
        while (coinOut !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        coinAck = 1'b1;
        step();
        coinAck = 1'b0;
        step();
        checks++;
        if (coinOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rm_second_coin: got %b want 1", coinOut);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, motorCoke, motorSprite, coinOut, busy} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL rm_async_clear: got %b want %b",
                     {gnt, done, err, motorCoke, motorSprite, coinOut, busy}, 9'b0);
        end
        step();
        rst = 1'b1;
        sawCoin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (coinOut !== 1'b0 || busy !== 1'b0) sawCoin = 1'b1;
        end
        checks++;
        if (sawCoin) begin
            errors++;
            $display("[TB] FAIL rm_no_coin: got activity after reset want none");
        end
        req = 2'b11; drinkType1 = 1'b1; change0 = 2'd0; change1 = 2'd0;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rm_priority: got %b want %b", gnt, 2'b01);
        end
        req = 2'b00;
        n = 0;
        while (done === 2'b00 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (done !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rm_done: got %b want %b", done, 2'b01);
        end
        step();
    endtask

`ifdef VEND_STATS_EN
    task automatic run_vend(input logic drink, input logic drop);
        int n;
        req = 2'b01; drinkType0 = drink; change0 = 2'd0; dropOk = drop;
        n = 0;
        while (gnt === 2'b00 && n < 20) begin
            step();
            n++;
        end
        req = 2'b00;
        n = 0;
        while (done === 2'b00 && n < 120) begin
            step();
            n++;
        end
        step();
        step();
    endtask

    task automatic test_stats();
        do_reset();
        run_vend(1'b0, 1'b1);
        run_vend(1'b1, 1'b1);
        run_vend(1'b0, 1'b1);
        run_vend(1'b0, 1'b0);
        checks++;
        if (cntCoke !== 16'd2 || cntSprite !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stats_counts: got coke=%0d sprite=%0d want coke=2 sprite=1", cntCoke, cntSprite);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_change3();
        test_reset_mid();
`ifdef VEND_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
